// File: rtl/locked_adder_response_checker.sv
// Grades a key sweep of a locked adder: counts vectors and mismatches against the
// golden unsigned sum per key, then presents one summary record when the key closes.
module locked_adder_response_checker #(
   parameter int W  = 16,
   parameter int KW = 32,
   parameter int CW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          vld_i,
   output logic          rdy_o,
   input  logic [W-1:0]  add1_i,
   input  logic [W-1:0]  add2_i,
   input  logic [W:0]    result_i,
   input  logic [KW-1:0] keyinput_i,
   input  logic          flush_i,
   output logic          sum_vld_o,
   input  logic          sum_rdy_i,
   output logic [KW-1:0] sum_key_o,
   output logic [CW-1:0] sum_vec_cnt_o,
   output logic [CW-1:0] sum_err_cnt_o,
   output logic [CW-1:0] sum_first_err_o,
   output logic          sum_unlocked_o
);

   typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [KW-1:0] cur_key_q, cur_key_d;
   logic [CW-1:0] vec_cnt_q, vec_cnt_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   logic [CW-1:0] first_err_q, first_err_d;
   logic [KW-1:0] sum_key_q, sum_key_d;
   logic [CW-1:0] sum_vec_q, sum_vec_d;
   logic [CW-1:0] sum_err_q, sum_err_d;
   logic [CW-1:0] sum_first_q, sum_first_d;
   logic          sum_unl_q, sum_unl_d;

   logic [W:0]    golden;
   logic          mismatch;
   logic          key_match;
   logic          accept;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   assign golden    = {1'b0, add1_i} + {1'b0, add2_i};
   assign mismatch  = (golden != result_i);
   assign key_match = (keyinput_i == cur_key_q);
   assign accept    = vld_i && rdy_o;

   always_comb begin
      state_d     = state_q;
      cur_key_d   = cur_key_q;
      vec_cnt_d   = vec_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      sum_key_d   = sum_key_q;
      sum_vec_d   = sum_vec_q;
      sum_err_d   = sum_err_q;
      sum_first_d = sum_first_q;
      sum_unl_d   = sum_unl_q;
      rdy_o       = 1'b0;
      case (state_q)
         IDLE: begin
            rdy_o = 1'b1;
            if (vld_i) begin
               cur_key_d   = keyinput_i;
               vec_cnt_d   = CNT_ONE;
               err_cnt_d   = mismatch ? CNT_ONE : '0;
               first_err_d = mismatch ? '0 : CNT_MAX;
               state_d     = RUN;
            end
         end
         RUN: begin
            rdy_o = key_match;
            if (accept) begin
               vec_cnt_d = sat_inc(vec_cnt_q);
               if (mismatch) begin
                  err_cnt_d = sat_inc(err_cnt_q);
                  if (err_cnt_q == '0) first_err_d = vec_cnt_q;
               end
            end
            // Snapshot the post-accept counts so a same-cycle flush vector is included.
            if (flush_i || (vld_i && !key_match)) begin
               state_d     = REPORT;
               sum_key_d   = cur_key_q;
               sum_vec_d   = vec_cnt_d;
               sum_err_d   = err_cnt_d;
               sum_first_d = first_err_d;
               sum_unl_d   = (err_cnt_d == '0);
            end
         end
         REPORT: begin
            if (sum_rdy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cur_key_q   <= '0;
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         sum_key_q   <= '0;
         sum_vec_q   <= '0;
         sum_err_q   <= '0;
         sum_first_q <= '0;
         sum_unl_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_key_q   <= cur_key_d;
         vec_cnt_q   <= vec_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         sum_key_q   <= sum_key_d;
         sum_vec_q   <= sum_vec_d;
         sum_err_q   <= sum_err_d;
         sum_first_q <= sum_first_d;
         sum_unl_q   <= sum_unl_d;
      end
   end

   assign sum_vld_o       = (state_q == REPORT);
   assign sum_key_o       = sum_key_q;
   assign sum_vec_cnt_o   = sum_vec_q;
   assign sum_err_cnt_o   = sum_err_q;
   assign sum_first_err_o = sum_first_q;
   assign sum_unlocked_o  = sum_unl_q;

endmodule

// File: tb/tb_locked_adder_response_checker.sv
// Directed bench for the locked adder response checker: a small per-key model
// pushes expected summaries to a queue, which are popped when sum_vld_o appears.
module tb_locked_adder_response_checker;

   typedef struct {
      logic [31:0] key;
      logic [7:0]  vec;
      logic [7:0]  err;
      logic [7:0]  first;
      logic        unl;
   } sum_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        vld_i;
   logic        rdy_o;
   logic [15:0] add1_i;
   logic [15:0] add2_i;
   logic [16:0] result_i;
   logic [31:0] keyinput_i;
   logic        flush_i;
   logic        sum_vld_o;
   logic        sum_rdy_i;
   logic [31:0] sum_key_o;
   logic [7:0]  sum_vec_cnt_o;
   logic [7:0]  sum_err_cnt_o;
   logic [7:0]  sum_first_err_o;
   logic        sum_unlocked_o;

   int tests = 0;
   int fails = 0;

   sum_t exp_q[$];

   // Bench-side model of the open key run
   logic        m_open = 1'b0;
   logic [31:0] m_key;
   logic [7:0]  m_vec, m_err, m_first;

   locked_adder_response_checker #(.W(16), .KW(32), .CW(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .vld_i(vld_i), .rdy_o(rdy_o),
      .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i),
      .keyinput_i(keyinput_i), .flush_i(flush_i),
      .sum_vld_o(sum_vld_o), .sum_rdy_i(sum_rdy_i), .sum_key_o(sum_key_o),
      .sum_vec_cnt_o(sum_vec_cnt_o), .sum_err_cnt_o(sum_err_cnt_o),
      .sum_first_err_o(sum_first_err_o), .sum_unlocked_o(sum_unlocked_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic [15:0] a, input logic [15:0] b,
                               input logic [16:0] r, input logic [31:0] k);
      logic mm;
      mm = (({1'b0, a} + {1'b0, b}) !== r);
      if (!m_open) begin
         m_open  = 1'b1;
         m_key   = k;
         m_vec   = 8'd1;
         m_err   = mm ? 8'd1 : 8'd0;
         m_first = mm ? 8'd0 : 8'hFF;
      end else begin
         if (mm && m_err == 8'd0) m_first = m_vec;
         if (mm && m_err != 8'hFF) m_err = m_err + 8'd1;
         if (m_vec != 8'hFF) m_vec = m_vec + 8'd1;
      end
      $display("[TB] vec key=%h a=%h b=%h r=%h cnt=%0d err=%0d", k, a, b, r, m_vec, m_err);
   endtask

   task automatic push_model();
      sum_t s;
      s.key = m_key; s.vec = m_vec; s.err = m_err; s.first = m_first;
      s.unl = (m_err == 8'd0);
      exp_q.push_back(s);
      m_open = 1'b0;
   endtask

   // Called at a negedge; the vector is accepted on the following posedge
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] r, input logic [31:0] k);
      vld_i = 1'b1; add1_i = a; add2_i = b; result_i = r; keyinput_i = k;
      #1;
      chk("rdy_accept", rdy_o, 1'b1);
      model_accept(a, b, r, k);
      @(negedge clk_i);
   endtask

   task automatic do_flush();
      vld_i = 1'b0; flush_i = 1'b1;
      push_model();
      @(negedge clk_i);
      flush_i = 1'b0;
      chk("sum_latency", sum_vld_o, 1'b1);
   endtask

   task automatic check_summary(output sum_t s);
      int n;
      n = 0;
      s = '{default: '0};
      while (!sum_vld_o && n < 4) begin
         @(negedge clk_i);
         n++;
      end
      if (!sum_vld_o) chk("sum_timeout", sum_vld_o, 1'b1);
      else if (exp_q.size() == 0) chk("sum_unexpected", sum_vld_o, 1'b0);
      else begin
         s = exp_q.pop_front();
         chk("sum_key", sum_key_o, s.key);
         chk("sum_vec", sum_vec_cnt_o, s.vec);
         chk("sum_err", sum_err_cnt_o, s.err);
         chk("sum_first", sum_first_err_o, s.first);
         chk("sum_unl", sum_unlocked_o, s.unl);
         chk("rdy_report", rdy_o, 1'b0);
         $display("[TB] summary key=%h vec=%0d err=%0d first=%h unl=%0d",
                  sum_key_o, sum_vec_cnt_o, sum_err_cnt_o, sum_first_err_o, sum_unlocked_o);
      end
   endtask

   task automatic release_sum();
      sum_rdy_i = 1'b1;
      @(negedge clk_i);
      sum_rdy_i = 1'b0;
      chk("sum_drop", sum_vld_o, 1'b0);
   endtask

   initial begin
      sum_t s;
      rst_ni = 1'b0; vld_i = 1'b0; flush_i = 1'b0; sum_rdy_i = 1'b0;
      add1_i = '0; add2_i = '0; result_i = '0; keyinput_i = '0;
      @(negedge clk_i);
      chk("rst_rdy", rdy_o, 1'b1);
      chk("rst_vld", sum_vld_o, 1'b0);
      chk("rst_key", sum_key_o, 32'h0);
      chk("rst_vec", sum_vec_cnt_o, 8'h0);
      chk("rst_err", sum_err_cnt_o, 8'h0);
      chk("rst_first", sum_first_err_o, 8'h0);
      chk("rst_unl", sum_unlocked_o, 1'b0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Correct key: three good vectors, flush
      send(16'h29AF, 16'h7A1B, 17'h0A3CA, 32'h094F5C9D);
      send(16'h8943, 16'hFFFF, 17'h18942, 32'h094F5C9D);
      send(16'h5555, 16'hAAAA, 17'h0FFFF, 32'h094F5C9D);
      do_flush();
      check_summary(s);
      release_sum();

      // Second result corrupted
      send(16'h29AF, 16'h7A1B, 17'h0A3CA, 32'h094F5C9D);
      send(16'h8943, 16'hFFFF, 17'h08942, 32'h094F5C9D);
      send(16'h5555, 16'hAAAA, 17'h0FFFF, 32'h094F5C9D);
      do_flush();
      check_summary(s);
      release_sum();

      // Key change closes K1; K2 vector waits on the bus through the report
      send(16'h29AF, 16'h7A1B, 17'h0A3CA, 32'h094F5C9D);
      send(16'h8943, 16'hFFFF, 17'h18942, 32'h094F5C9D);
      vld_i = 1'b1; add1_i = 16'hFADC; add2_i = 16'h00DC; result_i = 17'h0FBB8;
      keyinput_i = 32'h094F5C8D;
      #1;
      chk("rdy_keychg", rdy_o, 1'b0);
      push_model();
      @(negedge clk_i);
      check_summary(s);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("hold_vld", sum_vld_o, 1'b1);
         chk("hold_rdy", rdy_o, 1'b0);
         chk("hold_key", sum_key_o, s.key);
         chk("hold_vec", sum_vec_cnt_o, s.vec);
         chk("hold_err", sum_err_cnt_o, s.err);
         chk("hold_first", sum_first_err_o, s.first);
         chk("hold_unl", sum_unlocked_o, s.unl);
      end
      sum_rdy_i = 1'b1;
      @(negedge clk_i);
      sum_rdy_i = 1'b0;
      chk("idle_vld", sum_vld_o, 1'b0);
      chk("idle_rdy_pending", rdy_o, 1'b1);
      model_accept(16'hFADC, 16'h00DC, 17'h0FBB8, 32'h094F5C8D);
      @(negedge clk_i);
      do_flush();
      check_summary(s);
      release_sum();

      // Saturation: 300 mismatching vectors
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a, b;
         logic [16:0] g;
         a = 16'($urandom); b = 16'($urandom);
         g = {1'b0, a} + {1'b0, b};
         send(a, b, g ^ 17'h00001, 32'hDEADBEEF);
      end
      do_flush();
      check_summary(s);
      release_sum();

      // Reset mid-run discards the run
      for (int i = 0; i < 4; i++) send(16'h0001, 16'h0002, 17'h00003, 32'h12345678);
      vld_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      m_open = 1'b0;
      chk("mrst_rdy", rdy_o, 1'b1);
      chk("mrst_vld", sum_vld_o, 1'b0);
      chk("mrst_key", sum_key_o, 32'h0);
      chk("mrst_vec", sum_vec_cnt_o, 8'h0);
      chk("mrst_err", sum_err_cnt_o, 8'h0);
      chk("mrst_first", sum_first_err_o, 8'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("mrst_no_sum", sum_vld_o, 1'b0);
      end
      send(16'h0001, 16'h0002, 17'h00003, 32'h12345678);
      do_flush();
      check_summary(s);
      release_sum();

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
